uart_tx_mm: RTL and testbench

// Memory-mapped UART transmitter peripheral sitting behind the memory-map controller, beside GPIO/RAM/ROM.
// The core writes bytes into a small TX FIFO via store instructions.
// An 8N1 serializer drains the FIFO onto the tx pin.

---
 rtl/uart_tx_mm.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_mm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mm.sv
// Memory-mapped 8N1 UART transmitter: stores push bytes into a small TX FIFO,
// a serializer drains it onto tx, and a status word is readable for polling.
module uart_tx_mm #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        sel,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [2:0]         bitIdx, bitIdxNext;
    logic [7:0]         sh, shNext;
    logic               txNext;
    logic               busyNext;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [COUNT_W-1:0] count, countNext;
    logic               overflow;

    logic               fifoFull, fifoEmpty;
    logic               dataWrite, statusWrite;
    logic               push, pop, dropped;
    logic               txActive;

    // Only WD[7:0] (data) and WD[3] (overflow clear) carry meaning.
    logic               unusedWd;
    assign unusedWd = ^WD[31:8];

    assign fifoFull    = (count == FULL_COUNT);
    assign fifoEmpty   = (count == '0);
    assign dataWrite   = we && !sel;
    assign statusWrite = we && sel;
    assign txActive    = (state != IDLE);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
    assign push    = dataWrite && (!fifoFull || pop);
    assign dropped = dataWrite && fifoFull && !pop;

    assign RD = sel ? {28'h0, overflow, txActive, fifoEmpty, fifoFull} : 32'h0;

    always_comb begin
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + COUNT_W'(1);
            2'b01:   countNext = count - COUNT_W'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            if (dropped) begin
                overflow <= 1'b1;
            end else if (statusWrite && WD[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (rst && push) mem[wrPtr] <= WD[7:0];
    end

    // Serializer next-state, datapath and line output.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bitIdxNext = bitIdx;
        shNext     = sh;
        pop        = 1'b0;
        txNext     = 1'b1;
        busyNext   = 1'b0;

        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shNext    = mem[rdPtr];
                    cntNext   = '0;
                    stateNext = START;
                end
            end
            START: begin
                if (cnt == CNT_LAST) begin
                    cntNext    = '0;
                    bitIdxNext = 3'd0;
                    stateNext  = DATA;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cntNext    = '0;
                    shNext     = {1'b0, sh[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cntNext   = '0;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shNext[0];
            default: txNext = 1'b1;
        endcase

        busyNext = (stateNext != IDLE) || (countNext != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitIdx <= 3'd0;
            sh     <= 8'h00;
            tx     <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            bitIdx <= bitIdxNext;
            sh     <= shNext;
            tx     <= txNext;
            busy   <= busyNext;
        end
    end

endmodule

// File: tb/tb_uart_tx_mm.sv
// Randomized and directed bench for uart_tx_mm against a frame-timer reference
// model plus an independent line decoder.
module tb_uart_tx_mm;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we  = 1'b0;
    logic        sel = 1'b1;
    logic [31:0] WD  = 32'h0;
    logic [31:0] RD;
    logic        tx;
    logic        busy;

    uart_tx_mm #(
        .CLK_FREQ  (400),
        .BAUD      (100),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .sel (sel),
        .WD  (WD),
        .RD  (RD),
        .tx  (tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes, remaining cycles of the frame on the line.
    logic [7:0] q[$];
    logic [7:0] popLog[$];
    logic [7:0] rxLog[$];
    logic [7:0] cur = 8'h00;
    int         rem = 0;
    logic       ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep();
        logic popNow;
        if (!rst) begin
            q.delete();
            rem = 0;
            ovf = 1'b0;
        end else begin
            popNow = (rem == 0) && (q.size() > 0);
            if (we && !sel) begin
                if (q.size() < DEPTH || popNow) q.push_back(WD[7:0]);
                else ovf = 1'b1;
            end
            if (we && sel && WD[3]) ovf = 1'b0;
            if (rem > 0) begin
                rem--;
            end else if (popNow) begin
                cur = q.pop_front();
                popLog.push_back(cur);
                rem = FRAME;
            end
        end
    endtask

    function automatic logic expTx();
        int ph;
        int slot;
        if (rem == 0) return 1'b1;
        ph   = FRAME - rem;
        slot = ph / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return cur[slot-1];
    endfunction

    function automatic logic [31:0] expRd();
        if (!sel) return 32'h0;
        return {28'h0, ovf, rem > 0, q.size() == 0, q.size() == DEPTH};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        check("tx", {31'h0, tx}, {31'h0, expTx()});
        check("busy", {31'h0, busy}, {31'h0, (rem > 0) || (q.size() > 0)});
    endtask

    task automatic drive(input logic w, input logic s, input logic [31:0] d);
        we  = w;
        sel = s;
        WD  = d;
        #1;
        check("rd", RD, expRd());
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 32'h0);
    endtask

    task automatic waitIdle(input int budget);
        int b;
        b = budget;
        while (rem != 0 || q.size() != 0) begin
            if (b == 0) begin
                check("timeout_idle", {31'h0, busy}, 32'h0);
                return;
            end
            b--;
            idle();
            tick();
        end
    endtask

    // Independent line decoder: finds start bits and samples mid-bit.
    int         decPhase = -1;
    logic [7:0] decSh    = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            decPhase = -1;
        end else if (decPhase < 0) begin
            if (tx === 1'b0) decPhase = 0;
        end else begin
            decPhase++;
            if (decPhase == 2) check("dec_start", {31'h0, tx}, 32'h0);
            if (decPhase >= 6 && decPhase <= 34 && ((decPhase - 6) % 4) == 0)
                decSh[(decPhase - 6) / 4] = tx;
            if (decPhase == 38) check("dec_stop", {31'h0, tx}, 32'h1);
            if (decPhase == 39) begin
                rxLog.push_back(decSh);
                decPhase = -1;
            end
        end
    end

    logic [7:0] fillExp [6];

    initial begin
        fillExp[0] = 8'h01; fillExp[1] = 8'h02; fillExp[2] = 8'h03;
        fillExp[3] = 8'h04; fillExp[4] = 8'h05; fillExp[5] = 8'h77;

        // Reset
        repeat (3) tick();
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_status", RD, 32'h2);
        rst = 1'b1;
        idle();
        tick();

        // Single byte with exact timing
        rxLog.delete();
        drive(1'b1, 1'b0, 32'hA5);
        tick();
        for (int k = 1; k <= 41; k++) begin
            idle();
            tick();
            if (k == 1)  check("t2_start", {31'h0, tx}, 32'h0);
            if (k == 5)  check("t2_bit0", {31'h0, tx}, 32'h1);
            if (k == 9)  check("t2_bit1", {31'h0, tx}, 32'h0);
            if (k == 40) check("t2_busy40", {31'h0, busy}, 32'h1);
            if (k == 41) check("t2_busy41", {31'h0, busy}, 32'h0);
        end
        check("t2_rxcnt", rxLog.size(), 32'd1);
        if (rxLog.size() > 0) check("t2_rx", {24'h0, rxLog[0]}, 32'hA5);

        // Fill, overflow, clear, then push on the pop edge while full
        rxLog.delete();
        for (int b = 1; b <= 6; b++) begin
            drive(1'b1, 1'b0, 32'(b));
            tick();
        end
        idle();
        check("t3_status", RD, 32'hD);
        drive(1'b1, 1'b1, 32'h8);
        tick();
        idle();
        check("t3_clr", RD, 32'h5);
        for (int b = 0; b < 80 && !(rem == 0 && q.size() == DEPTH); b++) begin
            idle();
            tick();
        end
        drive(1'b1, 1'b0, 32'h77);
        tick();
        idle();
        check("t4_status", RD, 32'h5);
        waitIdle(400);
        check("t4_rxcnt", rxLog.size(), 32'd6);
        for (int i = 0; i < 6 && i < rxLog.size(); i++)
            check($sformatf("t4_rx%0d", i), {24'h0, rxLog[i]}, {24'h0, fillExp[i]});

        // Reset in the middle of data bit 3
        rxLog.delete();
        drive(1'b1, 1'b0, 32'hC3);
        tick();
        for (int b = 0; b < 60 && rem != 22; b++) begin
            idle();
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        check("t5_tx", {31'h0, tx}, 32'h1);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_status", RD, 32'h2);
        rst = 1'b1;

        // Upper write-data bits ignored, TXDATA reads zero
        drive(1'b1, 1'b0, 32'hFFFF_FF3C);
        check("t6_txdata", RD, 32'h0);
        tick();
        waitIdle(200);
        check("t6_rxcnt", rxLog.size(), 32'd1);
        if (rxLog.size() > 0) check("t6_rx", {24'h0, rxLog[0]}, 32'h3C);

        // Random traffic against the model
        rxLog.delete();
        popLog.delete();
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom);
            tick();
        end
        waitIdle(600);
        check("rnd_cnt", rxLog.size(), popLog.size());
        for (int i = 0; i < popLog.size() && i < rxLog.size(); i++)
            check("rnd_byte", {24'h0, rxLog[i]}, {24'h0, popLog[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
